// File: rtl/rx_frame_fsm_pkg.sv
// Shared types and constants for the UART receive frame FSM.
package rx_frame_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int PRESCALE_8     = 8;
  localparam int PRESCALE_16    = 16;
  localparam int PRESCALE_32    = 32;
  localparam int DATA_WIDTH_DEF = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic is_legal_prescale(input int p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/rx_edge_bit_counter.sv
// Oversampling edge counter, bit counter and 3-sample majority voter.
module rx_edge_bit_counter
  import rx_frame_fsm_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = 6,
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cnt_clr,
  input  logic                  bit_en,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [BCW-1:0]        bit_cnt,
  output logic                  bit_done,
  output logic                  smp_vld,
  output logic                  smp_bit
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d, half;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  s0_q, s0_d, s1_q, s1_d;

  assign half     = prescale >> 1;
  assign bit_done = (edge_cnt_q == prescale - PRESCALE_W'(1));
  // third sample is taken live, so the vote resolves at P/2+1
  assign smp_vld  = (edge_cnt_q == half + PRESCALE_W'(1));
  assign smp_bit  = maj3(s0_q, s1_q, rx_in);
  assign bit_cnt  = bit_cnt_q;

  always_comb begin
    edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
    if (cnt_clr || bit_done) edge_cnt_d = '0;
    bit_cnt_d = bit_cnt_q;
    if (!bit_en)
      bit_cnt_d = '0;
    else if (bit_done)
      bit_cnt_d = (bit_cnt_q == BCW'(DATA_WIDTH - 1)) ? '0 : bit_cnt_q + BCW'(1);
    s0_d = (edge_cnt_q == half - PRESCALE_W'(1)) ? rx_in : s0_q;
    s1_d = (edge_cnt_q == half) ? rx_in : s1_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
    end
  end

endmodule

// File: rtl/rx_frame_fsm.sv
// UART receive frame FSM: start/data/parity/stop sequencing and shift register.
// Define UART_RX_STRT_CHK_EN to reject start bits whose majority sample is 1.
module rx_frame_fsm
  import rx_frame_fsm_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  par_err,
  output logic                  par_chk_en,
  output logic                  odd_number_flag,
  output logic                  par_typ_q,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err_o,
  output logic                  stp_err,
  output logic                  strt_glitch
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  odd_q, odd_d, par_en_q, par_en_d, par_typ_d;
  logic                  smp_q, smp_d, par_cap_q, par_cap_d, par_err_o_q, par_err_o_d;
  logic                  start_entry, stop_end, bit_done, smp_vld, smp_bit;
  logic [BCW-1:0]        bit_cnt;

  assign start_entry = (state_q == ST_IDLE) && !RX_IN;

  rx_edge_bit_counter #(.DATA_WIDTH(DATA_WIDTH), .PRESCALE_W(PRESCALE_W)) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .cnt_clr  (state_q == ST_IDLE),
    .bit_en   (state_q == ST_DATA),
    .rx_in    (RX_IN),
    .prescale (Prescale),
    .bit_cnt  (bit_cnt),
    .bit_done (bit_done),
    .smp_vld  (smp_vld),
    .smp_bit  (smp_bit)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!RX_IN) state_d = ST_START;
      ST_START:  if (bit_done) begin
`ifdef UART_RX_STRT_CHK_EN
        state_d = smp_q ? ST_IDLE : ST_DATA;
`else
        state_d = ST_DATA;
`endif
      end
      ST_DATA:   if (bit_done && bit_cnt == BCW'(DATA_WIDTH - 1))
                   state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_done) state_d = ST_STOP;
      ST_STOP:   if (bit_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    par_chk_en = (state_q == ST_PARITY) && bit_done;
    stop_end   = (state_q == ST_STOP) && bit_done;
    stp_err    = stop_end && !smp_q;
    data_valid = stop_end && smp_q && !par_cap_q;
`ifdef UART_RX_STRT_CHK_EN
    strt_glitch = (state_q == ST_START) && bit_done && smp_q;
`else
    strt_glitch = 1'b0;
`endif
  end

  // smp_q holds the most recent voted bit; START and STOP decide on it at bit end
  always_comb begin
    p_data_d    = p_data_q;
    odd_d       = odd_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    par_cap_d   = par_cap_q;
    smp_d       = smp_vld ? smp_bit : smp_q;
    par_err_o_d = par_chk_en && par_err;
    if (start_entry) begin
      p_data_d  = '0;
      odd_d     = 1'b0;
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      par_cap_d = 1'b0;
    end
    if (smp_vld && state_q == ST_DATA) begin
      p_data_d = {smp_bit, p_data_q[DATA_WIDTH-1:1]};
      odd_d    = odd_q ^ smp_bit;
    end
    if (smp_vld && state_q == ST_PARITY) odd_d = odd_q ^ smp_bit;
    if (par_chk_en) par_cap_d = par_err;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_data_q    <= '0;
      odd_q       <= 1'b0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      par_cap_q   <= 1'b0;
      smp_q       <= 1'b0;
      par_err_o_q <= 1'b0;
    end else begin
      p_data_q    <= p_data_d;
      odd_q       <= odd_d;
      par_en_q    <= par_en_d;
      par_typ_q   <= par_typ_d;
      par_cap_q   <= par_cap_d;
      smp_q       <= smp_d;
      par_err_o_q <= par_err_o_d;
    end
  end

  assign P_DATA          = p_data_q;
  assign odd_number_flag = odd_q;
  assign par_err_o       = par_err_o_q;

endmodule

// File: tb/tb_rx_frame_fsm.sv
// Directed bench for rx_frame_fsm; a small parity-checker model drives par_err.
module tb_rx_frame_fsm;
  import rx_frame_fsm_pkg::*;

  logic       CLK = 1'b0, RST = 1'b1, RX_IN = 1'b0, PAR_EN = 1'b0, PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       par_err, par_chk_en, odd_number_flag, par_typ_q;
  logic       data_valid, par_err_o, stp_err, strt_glitch;
  logic [7:0] P_DATA;

  int n_run = 0, n_fail = 0, cyc = 0, t0 = 0, t1 = 0;
  int dv_n = 0, dv_cyc = 0, pce_n = 0, pce_cyc = 0, pe_n = 0, pe_cyc = 0;
  int se_n = 0, se_cyc = 0, sg_n = 0;
  int b_dv, b_pce, b_pe, b_se, b_sg;
  logic [7:0] dv_dat = 8'h00;
  logic       pce_odd = 1'b0, pce_typ = 1'b0;

  always #5 CLK = ~CLK;

  assign par_err = par_chk_en && (odd_number_flag != par_typ_q);

  rx_frame_fsm #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Prescale(Prescale), .par_err(par_err), .par_chk_en(par_chk_en),
    .odd_number_flag(odd_number_flag), .par_typ_q(par_typ_q), .P_DATA(P_DATA),
    .data_valid(data_valid), .par_err_o(par_err_o), .stp_err(stp_err),
    .strt_glitch(strt_glitch)
  );

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (data_valid) begin dv_n <= dv_n + 1; dv_cyc <= cyc; dv_dat <= P_DATA; end
    if (par_chk_en) begin
      pce_n <= pce_n + 1; pce_cyc <= cyc; pce_odd <= odd_number_flag; pce_typ <= par_typ_q;
    end
    if (par_err_o)   begin pe_n <= pe_n + 1; pe_cyc <= cyc; end
    if (stp_err)     begin se_n <= se_n + 1; se_cyc <= cyc; end
    if (strt_glitch) sg_n <= sg_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    RX_IN = b;
    repeat (int'(Prescale)) @(posedge CLK);
    #1;
  endtask

  task automatic snap();
    b_dv = dv_n; b_pce = pce_n; b_pe = pe_n; b_se = se_n; b_sg = sg_n;
  endtask

  // parity mode pins are inverted after the start bit to prove they were latched
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic pb, input logic sb);
    PAR_EN = pe; PAR_TYP = pt; t0 = cyc;
    drive_bit(1'b0);
    PAR_EN = ~pe; PAR_TYP = ~pt;
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pe) drive_bit(pb);
    drive_bit(sb);
    RX_IN = 1'b1;
  endtask

  initial begin
    logic [7:0] d5a;
    // reset dominates active-looking inputs
    PAR_EN = 1'b1; PAR_TYP = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rst_pdata", 32'(P_DATA), 32'h0);
    chk("rst_flags", 32'({odd_number_flag, par_typ_q, par_chk_en}), 32'h0);
    chk("rst_pulses", 32'({data_valid, par_err_o, stp_err, strt_glitch}), 32'h0);
    RX_IN = 1'b1;
    idle(1);
    RST = 1'b0;
    idle(5);
    chk("post_rst_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // P=8, no parity, 0xA5
    Prescale = 6'd8; snap();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    chk("a5_dv_cnt", 32'(dv_n - b_dv), 32'd1);
    chk("a5_dv_lat", 32'(dv_cyc - t0), 32'd80);
    chk("a5_data", 32'(dv_dat), 32'hA5);
    chk("a5_no_pce", 32'(pce_n - b_pce), 32'd0);
    chk("a5_no_stp", 32'(se_n - b_se), 32'd0);
    idle(20);
    chk("a5_hold", 32'(P_DATA), 32'hA5);

    // P=16, even parity, good parity bit
    Prescale = 6'd16; idle(4); snap();
    send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(4);
    chk("ev_pce_cnt", 32'(pce_n - b_pce), 32'd1);
    chk("ev_odd", 32'(pce_odd), 32'd0);
    chk("ev_typ", 32'(pce_typ), 32'd0);
    chk("ev_no_perr", 32'(pe_n - b_pe), 32'd0);
    chk("ev_dv_cnt", 32'(dv_n - b_dv), 32'd1);
    chk("ev_data", 32'(dv_dat), 32'h03);

    // even parity, bad parity bit
    idle(4); snap();
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(4);
    chk("bad_odd", 32'(pce_odd), 32'd1);
    chk("bad_perr_cnt", 32'(pe_n - b_pe), 32'd1);
    chk("bad_perr_lat", 32'(pe_cyc - pce_cyc), 32'd1);
    chk("bad_no_dv", 32'(dv_n - b_dv), 32'd0);
    chk("bad_no_stp", 32'(se_n - b_se), 32'd0);

    // odd parity, parity bit 1 is correct
    idle(4); snap();
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(4);
    chk("od_typ", 32'(pce_typ), 32'd1);
    chk("od_no_perr", 32'(pe_n - b_pe), 32'd0);
    chk("od_dv_cnt", 32'(dv_n - b_dv), 32'd1);

    // P=32, stop error then back-to-back good frame
    Prescale = 6'd32; idle(4); snap();
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);
    t1 = t0;
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    chk("b2b_stp_cnt", 32'(se_n - b_se), 32'd1);
    chk("b2b_stp_lat", 32'(se_cyc - t1), 32'd320);
    chk("b2b_dv_cnt", 32'(dv_n - b_dv), 32'd1);
    chk("b2b_dv_lat", 32'(dv_cyc - t0), 32'd321);
    chk("b2b_data", 32'(dv_dat), 32'h81);

    // 3-cycle low glitch
    Prescale = 6'd8; idle(4); snap();
    RX_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RX_IN = 1'b1;
`ifdef UART_RX_STRT_CHK_EN
    idle(20);
    chk("gl_pulse", 32'(sg_n - b_sg), 32'd1);
    chk("gl_idle", 32'(dut.state_q), 32'(ST_IDLE));
    idle(80);
    chk("gl_no_dv", 32'(dv_n - b_dv), 32'd0);
`else
    idle(100);
    chk("gl_tied0", 32'(sg_n - b_sg), 32'd0);
    chk("gl_dv_cnt", 32'(dv_n - b_dv), 32'd1);
    chk("gl_data", 32'(dv_dat), 32'hFF);
`endif

    // reset during data bit 4
    idle(4);
    d5a = 8'h5A;
    PAR_EN = 1'b1; PAR_TYP = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d5a[i]);
    RX_IN = d5a[4];
    repeat (3) @(posedge CLK);
    #2;
    chk("mid_pre_pdata", 32'(P_DATA), 32'hA0);
    RST = 1'b1;
    #1;
    chk("mid_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("mid_pdata", 32'(P_DATA), 32'h0);
    chk("mid_flags", 32'({odd_number_flag, par_typ_q}), 32'h0);
    chk("mid_cnts", 32'({dut.bit_cnt, dut.u_cnt.edge_cnt_q}), 32'h0);
    chk("mid_pulses", 32'({data_valid, par_err_o, stp_err, strt_glitch, par_chk_en}), 32'h0);
    RX_IN = 1'b1;
    idle(1);
    RST = 1'b0;
    idle(8); snap();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    chk("rec_dv_cnt", 32'(dv_n - b_dv), 32'd1);
    chk("rec_dv_lat", 32'(dv_cyc - t0), 32'd80);
    chk("rec_data", 32'(dv_dat), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_frame_fsm.md
RX_FRAME_FSM -- requirements
Module: rx_frame_fsm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: number of data bits per frame (5..8).
REQ-002 SHALL have parameter PRESCALE_W, default 6: width of the Prescale input.
REQ-003 SHALL have port CLK  input  1  RX oversampling clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port RX_IN  input  1  serial line, idle high.
REQ-006 SHALL have port PAR_EN  input  1  1 = frame carries a parity bit.
REQ-007 SHALL have port PAR_TYP  input  1  1 = odd parity, 0 = even parity.
REQ-008 SHALL have port Prescale  input  PRESCALE_W  oversampling ratio; legal values are 8, 16 and 32.
REQ-009 SHALL have port par_err  input  1  combinational result from the parity checker.
REQ-010 SHALL have ports par_chk_en, odd_number_flag, par_typ_q  output  1 each  to drive the parity checker.
REQ-011 SHALL have port P_DATA  output  DATA_WIDTH  received word, LSB first on the line.
REQ-012 SHALL have ports data_valid, par_err_o, stp_err, strt_glitch  output  1 each  one-cycle status pulses.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL leave IDLE for START on the first cycle RX_IN=0, clearing edge_cnt to 0 and latching PAR_EN and PAR_TYP (par_typ_q); later changes to PAR_EN/PAR_TYP SHALL be ignored until the next START.
REQ-015 SHALL count edge_cnt 0..Prescale-1 per bit period, wrapping to 0, and SHALL advance the bit position on the wrap.
REQ-016 SHALL sample RX_IN at edge_cnt = P/2-1, P/2 and P/2+1 (P = Prescale); the bit value SHALL be the 2-of-3 majority.
REQ-017 SHALL shift each DATA bit into P_DATA LSB first; DATA SHALL last exactly DATA_WIDTH bit periods (bit_cnt 0..DATA_WIDTH-1).
REQ-018 SHALL set odd_number_flag = XOR of all sampled data bits and the sampled parity bit; it is cleared on START entry.
REQ-019 From DATA, the FSM SHALL go to PARITY if latched PAR_EN=1, else to STOP.
REQ-020 SHALL assert par_chk_en for exactly one cycle at edge_cnt = Prescale-1 of PARITY, with odd_number_flag final in that cycle; par_err SHALL be captured in that cycle.
REQ-021 SHALL pulse par_err_o one cycle after a captured par_err = 1.
REQ-022 At edge_cnt = Prescale-1 of STOP: if sampled stop = 0, SHALL pulse stp_err; otherwise, if no parity error is captured, SHALL pulse data_valid; the FSM SHALL then go to IDLE.
REQ-023 P_DATA SHALL hold its value from the data_valid pulse until the next START entry.
REQ-024 With RX_IN=0 in the cycle after STOP ends, a new START SHALL begin (back-to-back frames, no idle gap needed).
REQ-025 Prescale changes mid-frame are unsupported; behaviour is undefined until IDLE.

Reset
REQ-026 RST=1 SHALL force IDLE from any state, including mid-frame, with edge_cnt, bit_cnt, P_DATA, odd_number_flag and par_typ_q all 0, and every pulse output 0.
REQ-027 After RST is released, the FSM SHALL ignore RX_IN until it sees a 0 in IDLE.

Configuration
REQ-028 Macro UART_RX_STRT_CHK_EN defined: the START majority sample SHALL be checked at edge_cnt = Prescale-1; a 1 SHALL pulse strt_glitch and return to IDLE, a 0 SHALL proceed to DATA.
REQ-029 Macro UART_RX_STRT_CHK_EN undefined: START SHALL always proceed to DATA after one bit period, and strt_glitch SHALL be tied to 0.

Structure
REQ-030 A shared package SHALL hold the state encoding (3-bit), the legal Prescale constants 8/16/32 and the DATA_WIDTH default.
REQ-031 Sub-module rx_edge_bit_counter SHALL hold edge_cnt, bit_cnt and the 3-sample majority voter; the FSM and shift register SHALL remain in rx_frame_fsm.

Verification
REQ-032 Prescale=8, PAR_EN=0, byte 0xA5 -> P_DATA=0xA5, one data_valid pulse at 80 cycles after the start falling edge, and par_chk_en never asserted.
REQ-033 Prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x03, parity bit 0 -> par_chk_en one cycle with odd_number_flag=0; checker returns 0; data_valid pulses.
REQ-034 Same stimulus with parity bit 1 -> odd_number_flag=1, par_err=1, par_err_o pulses, no data_valid.
REQ-035 Prescale=32, byte 0x7E with stop bit 0 -> stp_err pulses and data_valid stays 0; the next frame 0x81 sent back-to-back is received correctly.
REQ-036 With UART_RX_STRT_CHK_EN defined, a 3-cycle low glitch on RX_IN -> strt_glitch pulses, FSM in IDLE, and no data_valid.
REQ-037 RST asserted during bit 4 of a frame -> all outputs 0 immediately, FSM in IDLE, and the following full frame 0x5A is received correctly.
